io_hub: RTL
===========

# io_hub

Parametrised J1 I/O-page peripheral block for page 0xF of the J1 I/O space, replacing the hard-wired status latch and direct UART strobe of the DE0 board top. It provides NREG CPU-writable 16-bit output registers (seven-segment, LEDs), a buffered UART transmit path with a FIFO draining to the JTAG loader's byte port under its busy handshake, and a free-running 32-bit cycle counter with atomic read. It sits between the J1 `io_*` bus and the board-level consumers.

## Interface
- NREG, 2, number of 16-bit output registers, 1..8
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..128
- REG_RESET, 16'h8888, reset value of every output register
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- io_addr  in  16  J1 I/O address
- io_wdata  in  16  J1 write data
- io_wr  in  1  write strobe, one cycle
- io_rd  in  1  read strobe, one cycle
- io_rdata  out  16  read data, combinational from io_addr
- regs_out  out  16*NREG  register i at bits [16i+15:16i]
- uart_data  out  8  byte to loader
- uart_we  out  1  one-cycle byte strobe
- uart_busy  in  1  loader busy; no strobe while high

## Operation
- Decoding only when io_addr[15:12]==4'hF; anything else is ignored and reads 0.
- 0xF000+i, i<NREG: register i.
  - Write loads io_wdata[15:0].
  - Read returns its value.
  - i>=NREG reads 0 and writes are ignored.
- 0xF100 write: push io_wdata[7:0] into the TX FIFO.
  - If the FIFO is full at that edge, the byte is dropped and the sticky `ovf` bit is set.
  - A pop in the same cycle does not rescue the push.
- 0xF100 read: status word.
  - Bit 15 = ovf, bit 14 = full, bit 13 = empty, bits [7:0] = occupancy; other bits 0.
  - io_rd at 0xF100 clears ovf at the edge. If an overflow occurs in the same cycle, ovf ends set.
- 0xF200 read: returns counter[15:0] and latches counter[31:16] into `shadow` at the same edge.
- 0xF201 read: returns shadow.
- Counter increments every cycle and wraps 0xFFFFFFFF->0. Writes to 0xF2xx are ignored.
- Drain FSM, states IDLE, SEND, HOLD:
  - IDLE->SEND when FIFO non-empty and uart_busy==0.
  - SEND: uart_we=1 for one cycle, uart_data=FIFO head, pop at the edge, then go to HOLD.
  - HOLD: one cycle gap so the loader can raise busy, then go to IDLE.
- Reset values:
  - regs_out = REG_RESET in every field.
  - FIFO empty, ovf=0, counter=0, shadow=0.
  - FSM in IDLE, uart_we=0, uart_data=0.

## Timing
- Register write is visible on regs_out and io_rdata the cycle after the io_wr edge.
- Minimum push-to-uart_we latency is 2 cycles:
  - Edge 0: push.
  - Edge 1: FSM goes IDLE->SEND.
  - uart_we is high during cycle 2.
- Maximum drain rate is one byte per 3 cycles when uart_busy stays 0.
- uart_busy is sampled only in IDLE. Busy rising during HOLD delays the next send.
- Occupancy never exceeds FIFO_DEPTH. Simultaneous push (not full) and pop leaves occupancy unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is log2(FIFO_DEPTH)+1 bits, zero-extended into bits [7:0].
- Reset mid-SEND: uart_we drops at the reset edge and FIFO contents are discarded.

## Structure
- Shared package `io_pkg`:
  - page constant 4'hF
  - offsets REG_BASE=12'h000, UART=12'h100, CNT_LO=12'h200, CNT_HI=12'h201
  - status bit positions
  - drain FSM state encoding
- Sub-module `sync_fifo` (params WIDTH=8, DEPTH) has push/pop/full/empty/count/head ports. Drop-on-full policy lives in io_hub, not the FIFO.

## Test plan
- Reset, then read 0xF000/0xF001 -> 0x8888 each; 0xF100 -> 0x2000 (empty).
- Write 0x1234 to 0xF001, then read -> 0x1234 and regs_out[31:16]=0x1234; write to 0xF005 with NREG=2 -> no change, reads 0.
- Push 0x41, 0x42 with uart_busy=0 -> uart_we pulses carry 0x41 then 0x42, 3 cycles apart; first pulse 2 cycles after the push.
- Hold uart_busy=1 and push 17 bytes at depth 16 -> status 0xC010. Read again -> 0x4010 (ovf cleared). Release busy -> exactly the first 16 bytes appear, in order.
- Counter atomicity: read 0xF200 at counter 0x0001FFFF, then 0xF201 on a later cycle -> 0xFFFF then 0x0001, despite the intervening carry.
- Assert reset during SEND -> uart_we=0 next cycle, status reads 0x2000 afterwards, no stale bytes are emitted.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the J1 I/O page 0xF peripheral hub.
// Address map, status bit positions and drain FSM encoding.
package io_pkg;

    localparam logic [3:0]  IO_PAGE  = 4'hF;

    localparam logic [11:0] REG_BASE = 12'h000;
    localparam logic [11:0] OFS_UART = 12'h100;
    localparam logic [11:0] CNT_LO   = 12'h200;
    localparam logic [11:0] CNT_HI   = 12'h201;

    localparam int STAT_OVF   = 15;
    localparam int STAT_FULL  = 14;
    localparam int STAT_EMPTY = 13;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_SEND = 2'd1,
        DR_HOLD = 2'd2
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap naturally.
// Push on full and pop on empty are ignored here; policy lives upstream.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/io_hub.sv
// J1 I/O page 0xF hub: output registers, buffered UART TX drain,
// and a free-running 32-bit cycle counter with atomic split read.
module io_hub
    import io_pkg::*;
#(
    parameter int          NREG       = 2,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] REG_RESET  = 16'h8888
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       io_addr,
    input  logic [15:0]       io_wdata,
    input  logic              io_wr,
    input  logic              io_rd,
    output logic [15:0]       io_rdata,
    output logic [16*NREG-1:0] regs_out,
    output logic [7:0]        uart_data,
    output logic              uart_we,
    input  logic              uart_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        w_page;
    logic [11:0] w_off;
    logic [11:0] w_reg_idx;
    logic        w_reg_hit;
    logic        w_uart_hit;
    logic        w_lo_hit;
    logic        w_hi_hit;

    assign w_page     = (io_addr[15:12] == IO_PAGE);
    assign w_off      = io_addr[11:0];
    assign w_reg_idx  = w_off - REG_BASE;
    assign w_reg_hit  = w_page && (w_reg_idx < 12'(NREG));
    assign w_uart_hit = w_page && (w_off == OFS_UART);
    assign w_lo_hit   = w_page && (w_off == CNT_LO);
    assign w_hi_hit   = w_page && (w_off == CNT_HI);

    logic [15:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= REG_RESET;
        end else if (io_wr && w_reg_hit) begin
            for (int i = 0; i < NREG; i++)
                if (w_reg_idx == 12'(i))
                    r_regs[i] <= io_wdata;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_regs
        assign regs_out[16*g +: 16] = r_regs[g];
    end

    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_ovf_evt;
    logic          r_ovf;

    // A push that meets a full FIFO is lost even if a pop frees a slot.
    assign w_push    = io_wr && w_uart_hit && !w_full;
    assign w_ovf_evt = io_wr && w_uart_hit && w_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_txq (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (io_wdata[7:0]),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_ovf_evt)
            r_ovf <= 1'b1;
        else if (io_rd && w_uart_hit)
            r_ovf <= 1'b0;
    end

    logic [31:0] r_cnt;
    logic [15:0] r_shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_shadow <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (io_rd && w_lo_hit)
                r_shadow <= r_cnt[31:16];
        end
    end

    drain_state_t r_state;
    drain_state_t w_state_nx;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= DR_IDLE;
        else
            r_state <= w_state_nx;
    end

    // HOLD leaves the loader one cycle to raise busy before we resample it.
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        uart_we    = 1'b0;
        uart_data  = 8'h00;
        unique case (r_state)
            DR_IDLE: begin
                if (!w_empty && !uart_busy)
                    w_state_nx = DR_SEND;
            end
            DR_SEND: begin
                uart_we    = 1'b1;
                uart_data  = w_head;
                w_pop      = 1'b1;
                w_state_nx = DR_HOLD;
            end
            DR_HOLD: begin
                w_state_nx = DR_IDLE;
            end
            default: begin
                w_state_nx = DR_IDLE;
            end
        endcase
    end

    logic [15:0] w_status;

    always_comb begin
        w_status             = 16'h0000;
        w_status[STAT_OVF]   = r_ovf;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[7:0]        = 8'(w_count);
    end

    always_comb begin
        io_rdata = 16'h0000;
        if (w_reg_hit) begin
            for (int i = 0; i < NREG; i++)
                if (w_reg_idx == 12'(i))
                    io_rdata = r_regs[i];
        end else if (w_uart_hit) begin
            io_rdata = w_status;
        end else if (w_lo_hit) begin
            io_rdata = r_cnt[15:0];
        end else if (w_hi_hit) begin
            io_rdata = r_shadow;
        end
    end

endmodule
